buf_fanout_pipe: RTL
====================

BUF_FANOUT_PIPE -- requirements
Module: buf_fanout_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 26, meaning data bits per channel (1..64).
REQ-002 SHALL have parameter NCH, default 25, meaning channel count (1..32).
REQ-003 SHALL have parameter DEPTH, default 2, meaning per-channel buffer entries (1..8).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port mode_req, input, 1, requested mode (0 = per-channel, 1 = broadcast from channel 0).
REQ-007 SHALL have port inp, input, NCH*WIDTH, channel c data at bits [c*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, NCH, per-channel producer valid.
REQ-009 SHALL have port in_ready, output, NCH, per-channel accept.
REQ-010 SHALL have port otp, output, NCH*WIDTH, channel c data at bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid, output, NCH, per-channel output valid.
REQ-012 SHALL have port out_ready, input, NCH, per-channel consumer ready.
REQ-013 SHALL have port mode, output, 1, mode currently in effect.
REQ-014 SHALL have port busy, output, 1, high while any channel buffer is non-empty.

Function
REQ-015 SHALL give each channel a FIFO of DEPTH entries; a word is accepted when in_valid and in_ready are both high at a rising edge.
REQ-016 SHALL make an accepted word visible on otp/out_valid exactly 1 cycle after acceptance when the channel was empty (no combinational in-to-out path).
REQ-017 SHALL pop a word when out_valid and out_ready are both high; otp SHALL hold stable while out_valid is high and out_ready is low.
REQ-018 SHALL, in per-channel mode, drive in_ready[c] high iff channel c is not full, or is full and popping in the same cycle.
REQ-019 SHALL sustain one word per cycle per channel when DEPTH >= 2 and out_ready is held high.
REQ-020 SHALL, in broadcast mode, drive in_ready[0] high only when every channel can accept; on acceptance, write inp channel 0 data into all NCH FIFOs in the same cycle.
REQ-021 SHALL, in broadcast mode, hold in_ready[1..NCH-1] low and ignore in_valid[1..NCH-1] and their data.
REQ-022 SHALL handle push and pop on a full channel in the same cycle with no loss, so occupancy is unchanged.
REQ-023 SHALL handle push and pop on an empty channel as an accept only; the word appears the following cycle.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH, including non-power-of-two DEPTH.
REQ-025 SHALL update mode from mode_req only on a cycle when busy is low and no word is accepted on any channel.
REQ-026 SHALL, while mode differs from mode_req, hold all in_ready low until the switch occurs, so that the buffers drain.
REQ-027 SHALL drive out_valid[c] low when channel c is empty; otp content is don't-care then but SHALL be deterministic (last value held).

Reset
REQ-028 SHALL, while rst_n is low, force out_valid = 0, in_ready = 0, busy = 0, mode = 0, otp = 0, and empty all FIFOs.
REQ-029 SHALL discard in-flight words when reset is asserted mid-transfer; no word accepted before reset SHALL appear after it.
REQ-030 SHALL raise in_ready no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL take the mode encoding (PER_CH = 0, BCAST = 1) and default parameter constants from shared package buf_pkg.
REQ-032 SHALL implement one channel FIFO as sub-module buf_fifo_ch (WIDTH, DEPTH), instantiated NCH times via generate.
REQ-033 SHALL keep mode control, broadcast ready-AND and busy-OR in the top level only.

Verification
REQ-034 SHALL check pass-through: DEPTH=2, NCH=25, channel 3 sends 0x2AAAAAA with out_ready=1 -> out_valid[3] high 1 cycle later, otp[3] = 0x2AAAAAA, other channels quiet.
REQ-035 SHALL check backpressure: DEPTH=2, out_ready[0]=0, push 0x1, 0x2, 0x3 -> in_ready[0] low after 2 accepts; release -> 0x1, 0x2, 0x3 in order, none lost.
REQ-036 SHALL check broadcast: mode_req=1 at idle, push 0x155 on channel 0 -> all 25 channels present 0x155 next cycle; hold out_ready[7]=0 -> in_ready[0] low once channel 7 is full.
REQ-037 SHALL check mode switch under load: channel 5 holds 2 words with mode_req toggled -> all in_ready low, mode unchanged until 2 pops, then mode flips the cycle after busy falls.
REQ-038 SHALL check mid-transfer reset: 4 channels with full FIFOs, pulse rst_n low asynchronously between edges -> out_valid = 0 immediately, no stale word after release.
REQ-039 SHALL check wrap: DEPTH=3, stream 10 sequential words with random out_ready -> output sequence 0..9 exact.

Source files
------------

// File: rtl/buf_pkg.sv
// Shared mode encoding and default sizing for the buffered fan-out pipe.
package buf_pkg;

  typedef enum logic {
    PER_CH = 1'b0,
    BCAST  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 26;
  localparam int DEF_NCH   = 25;
  localparam int DEF_DEPTH = 2;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/buf_fanout_pipe_if.sv
// One valid/ready data stream; master drives data/valid, slave drives ready.
interface buf_fanout_pipe_if import buf_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/buf_fifo_ch.sv
// Single-channel FIFO; output is taken from storage, so there is no
// combinational path from the write side to the read side.
module buf_fifo_ch import buf_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  buf_fanout_pipe_if.slave  up,
  buf_fanout_pipe_if.master dn
);
  localparam int PW = ptr_bits(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_data;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // When empty, keep presenting the most recently popped word.
  assign dn.valid = (count != '0);
  assign dn.data  = dn.valid ? mem[rd_ptr] : last_data;
  assign do_pop   = dn.valid & dn.ready;
  assign up.ready = (count != FULL) | do_pop;
  assign do_push  = up.valid & up.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_data <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= up.data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        last_data <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buf_fanout_pipe.sv
// Per-channel buffered pipe with optional broadcast of channel 0 to all channels.
//   state  | meaning
//   PER_CH | each channel accepts its own input
//   BCAST  | channel 0 input written to every channel at once
module buf_fanout_pipe import buf_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_req,
  input  logic [NCH*WIDTH-1:0] inp,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [NCH*WIDTH-1:0] otp,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 mode,
  output logic                 busy
);
  mode_e          mode_q;
  mode_e          mode_d;
  logic           run;
  logic           open;
  logic           acc0;
  logic [NCH-1:0] can;
  logic [NCH-1:0] push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= PER_CH;
      run    <= 1'b0;
    end else begin
      mode_q <= mode_d;
      run    <= 1'b1;
    end
  end

  // A pending mode change closes all inputs so the buffers drain first.
  always_comb begin
    mode_d = mode_q;
    if (!busy && (push == '0)) mode_d = mode_e'(mode_req);
  end

  assign mode = mode_q;
  assign busy = |out_valid;
  assign open = run & (mode_q == mode_e'(mode_req));

  always_comb begin
    in_ready = '0;
    push     = '0;
    acc0     = 1'b0;
    if (mode_q == BCAST) begin
      in_ready[0] = open & (&can);
      acc0        = in_valid[0] & open & (&can);
      push        = {NCH{acc0}};
    end else begin
      in_ready = can & {NCH{open}};
      push     = in_valid & can & {NCH{open}};
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    buf_fanout_pipe_if #(.WIDTH(WIDTH)) up_if ();
    buf_fanout_pipe_if #(.WIDTH(WIDTH)) dn_if ();

    assign up_if.data  = (mode_q == BCAST) ? inp[0 +: WIDTH] : inp[c*WIDTH +: WIDTH];
    assign up_if.valid = push[c];
    assign can[c]      = up_if.ready;

    assign dn_if.ready             = out_ready[c];
    assign otp[c*WIDTH +: WIDTH]   = dn_if.data;
    assign out_valid[c]            = dn_if.valid;

    buf_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .up    (up_if),
      .dn    (dn_if)
    );
  end

endmodule
